// File: rtl/fir_pkg.sv
// Shared constants and types for the serial symmetric FIR tap scheduler.
// FIR_ROUND_EN selects a round-half-up accumulator preload instead of zero.
package fir_pkg;

  localparam int DATA_W    = 32;
  localparam int COEF_W    = 17;
  localparam int NTAPS     = 127;
  localparam int HALF      = (NTAPS + 1) / 2;
  localparam int ACC_W     = 56;
  localparam int OUT_SHIFT = 24;

  localparam int ADDR_W = $clog2(HALF);
  localparam int PTR_W  = $clog2(NTAPS);
  localparam int SUM_W  = DATA_W + 1;
  localparam int PROD_W = SUM_W + COEF_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic [PTR_W-1:0]         ptr_t;
  typedef logic [ADDR_W-1:0]        addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LAST  = 2'd2,
    OUT   = 2'd3
  } state_t;

`ifdef FIR_ROUND_EN
  localparam acc_t ACC_INIT = acc_t'(longint'(1) << (OUT_SHIFT - 1));
`else
  localparam acc_t ACC_INIT = '0;
`endif

  // (base - off) mod NTAPS for base, off in [0, NTAPS-1]
  function automatic ptr_t hist_index(input ptr_t base, input ptr_t off);
    logic [PTR_W:0] t;
    t = {1'b0, base} + (PTR_W + 1)'(NTAPS) - {1'b0, off};
    if (t >= (PTR_W + 1)'(NTAPS)) begin
      t = t - (PTR_W + 1)'(NTAPS);
    end
    return ptr_t'(t);
  endfunction

endpackage

// File: rtl/fir_preadd_mac.sv
// Registered operand pair, symmetric pre-add, multiply and wrapping accumulate.
// Exposes the slice of the accumulator value about to be registered.
module fir_preadd_mac
  import fir_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    zero_b,
  input  logic    clear,
  input  logic    en,
  input  sample_t a_in,
  input  sample_t b_in,
  input  coef_t   coef,
  output sample_t result_next
);

  sample_t a_reg;
  sample_t b_reg;
  acc_t    acc_reg;
  acc_t    acc_next;
  sum_t    sum;
  prod_t   prod;

  always_comb begin
    sum      = sum_t'(a_reg) + sum_t'(b_reg);
    prod     = prod_t'(sum) * prod_t'(coef);
    acc_next = acc_reg;
    if (clear) begin
      acc_next = ACC_INIT;
    end else if (en) begin
      acc_next = acc_reg + acc_t'(prod);
    end
  end

  assign result_next = acc_next[OUT_SHIFT+DATA_W-1:OUT_SHIFT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else begin
      if (load) begin
        a_reg <= a_in;
        b_reg <= zero_b ? '0 : b_in;
      end
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/fir_tap_scheduler.sv
// Serial 127-tap symmetric FIR controller: history buffer, tap indexing, FSM.
// Build with FIR_ROUND_EN defined for round-half-up output.
module fir_tap_scheduler
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  state_t  state_reg;
  state_t  state_next;
  ptr_t    wr_ptr_reg;
  ptr_t    base_reg;
  addr_t   k_reg;
  logic    mac_en_reg;
  sample_t out_data_reg;
  sample_t result_next;
  sample_t hist [NTAPS];
  ptr_t    idx_a;
  ptr_t    idx_b;
  logic    accept;
  logic    centre;

  assign accept = in_valid && (state_reg == IDLE);
  assign centre = (k_reg == addr_t'(HALF - 1));

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (centre) begin
          state_next = LAST;
        end
      end
      LAST: state_next = OUT;
      OUT: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Newest sample at base; its mirror partner sits NTAPS-1-k samples back.
  always_comb begin
    idx_a = hist_index(base_reg, ptr_t'(k_reg));
    idx_b = hist_index(base_reg, ptr_t'(NTAPS - 1) - ptr_t'(k_reg));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      base_reg     <= '0;
      k_reg        <= '0;
      mac_en_reg   <= 1'b0;
      out_data_reg <= '0;
    end else begin
      if (accept) begin
        base_reg   <= wr_ptr_reg;
        wr_ptr_reg <= (wr_ptr_reg == ptr_t'(NTAPS - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      k_reg      <= (state_reg == ISSUE) ? k_reg + 1'b1 : '0;
      // ROM data lags the address by one cycle, so the MAC trails issue.
      mac_en_reg <= (state_reg == ISSUE);
      if (state_reg == LAST) begin
        out_data_reg <= result_next;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_hist
      sample_t entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (accept && (wr_ptr_reg == ptr_t'(gi))) begin
          entry_reg <= in_data;
        end
      end
      assign hist[gi] = entry_reg;
    end
  endgenerate

  fir_preadd_mac u_mac (
    .clk         (clk),
    .rst         (rst),
    .load        (state_reg == ISSUE),
    .zero_b      (centre),
    .clear       (accept),
    .en          (mac_en_reg),
    .a_in        (hist[idx_a]),
    .b_in        (hist[idx_b]),
    .coef        (coef_data),
    .result_next (result_next)
  );

  assign coef_addr = k_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Self-checking bench for fir_tap_scheduler against a direct-convolution model.
module tb_fir_tap_scheduler;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic [5:0]         coef_addr;
  logic [16:0]        coef_data;
  logic               out_valid;
  logic [31:0]        out_data;
  logic               busy;

  logic signed [16:0] rom [64];
  logic signed [31:0] xs[$];
  logic signed [31:0] stim[$];
  logic [31:0]        outs[$];
  int                 lats[$];
  int                 accs[$];
  int                 viol;
  int                 n_cmp = 0;
  int                 n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) coef_data <= rom[coef_addr];

  fir_tap_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  // y[n] = sum_j h[j]*x[n-j], h symmetric; result taken as bits [55:24] of a 56-bit wrap.
  function automatic logic [31:0] ref_y(input int n);
    longint      acc;
    logic [63:0] bits;
`ifdef FIR_ROUND_EN
    acc = longint'(1) << 23;
`else
    acc = 0;
`endif
    for (int j = 0; j < 127; j++) begin
      if (n - j >= 0) acc += longint'(rom[(j < 64) ? j : 126 - j]) * longint'(xs[n - j]);
    end
    bits = acc;
    return bits[55:24];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    xs.delete();
  endtask

  // Offers every sample of stim with in_valid held continuously; records outputs.
  task automatic run_stream(output int base);
    int t, idx, n, limit;
    n = stim.size();
    base = xs.size();
    outs.delete(); lats.delete(); accs.delete();
    viol = 0; t = 0; idx = 0; limit = n * 67 + 200;
    @(negedge clk);
    in_valid = (n > 0);
    if (n > 0) in_data = stim[0];
    while (outs.size() < n && t < limit) begin
      if (busy && in_ready) viol++;
      if (out_valid) begin
        outs.push_back(out_data);
        lats.push_back((outs.size() <= accs.size()) ? t - accs[outs.size() - 1] : -1);
        $display("txn %0d: out=%0d lat=%0d", outs.size() - 1, $signed(out_data), lats[$]);
      end
      if (in_valid && in_ready) begin
        accs.push_back(t);
        xs.push_back(stim[idx]);
        idx++;
        @(posedge clk);
        #1;
        if (idx < n) in_data = stim[idx];
        else in_valid = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_cmp++; if (coef_addr !== 6'd0) begin n_err++; $display("FAIL reset_coef_addr got=%0d want=0", coef_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    xs.delete();
  endtask

  task automatic test_impulse(input bit reset_first);
    int base;
    int ki[4] = '{0, 63, 126, 127};
    int kv[4] = '{1, 64, 1, 0};
    if (reset_first) do_reset();
    for (int k = 0; k < 64; k++) rom[k] = 17'(k + 1);
    stim.delete();
    stim.push_back(32'sd1 <<< 24);
    repeat (127) stim.push_back(32'sd0);
    run_stream(base);
    n_cmp++; if (outs.size() != 128) begin n_err++; $display("FAIL impulse_count got=%0d want=128", outs.size()); end
    for (int i = 0; i < outs.size(); i++) begin
      n_cmp++;
      if (outs[i] !== ref_y(base + i)) begin n_err++; $display("FAIL impulse_y[%0d] got=%0d want=%0d", i, $signed(outs[i]), $signed(ref_y(base + i))); end
    end
    for (int i = 0; i < 4; i++) begin
      if (ki[i] < outs.size()) begin
        n_cmp++;
        if ($signed(outs[ki[i]]) != kv[i]) begin n_err++; $display("FAIL impulse_point[%0d] got=%0d want=%0d", ki[i], $signed(outs[ki[i]]), kv[i]); end
      end
    end
  endtask

  task automatic test_dc();
    int base;
    do_reset();
    for (int k = 0; k < 64; k++) rom[k] = 17'sd1;
    stim.delete();
    repeat (128) stim.push_back(32'sd1 <<< 24);
    run_stream(base);
    n_cmp++; if (outs.size() != 128) begin n_err++; $display("FAIL dc_count got=%0d want=128", outs.size()); end
    for (int i = 0; i < outs.size(); i++) begin
      n_cmp++;
      if ($signed(outs[i]) != ((i < 127) ? i + 1 : 127)) begin n_err++; $display("FAIL dc_y[%0d] got=%0d want=%0d", i, $signed(outs[i]), (i < 127) ? i + 1 : 127); end
    end
  endtask

  task automatic test_throughput();
    int base;
    do_reset();
    for (int k = 0; k < 64; k++) rom[k] = 17'($urandom);
    stim.delete();
    repeat (6) stim.push_back(32'($urandom));
    run_stream(base);
    n_cmp++; if (outs.size() != 6) begin n_err++; $display("FAIL tput_count got=%0d want=6", outs.size()); end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL tput_ready_while_busy got=%0d want=0", viol); end
    for (int i = 0; i < outs.size(); i++) begin
      n_cmp++; if (lats[i] != 66) begin n_err++; $display("FAIL tput_latency[%0d] got=%0d want=66", i, lats[i]); end
      n_cmp++; if (outs[i] !== ref_y(base + i)) begin n_err++; $display("FAIL tput_y[%0d] got=%0d want=%0d", i, $signed(outs[i]), $signed(ref_y(base + i))); end
    end
    for (int i = 1; i < accs.size(); i++) begin
      n_cmp++; if (accs[i] - accs[i-1] != 67) begin n_err++; $display("FAIL tput_period[%0d] got=%0d want=67", i, accs[i] - accs[i-1]); end
    end
  endtask

  task automatic test_extremes();
    int base;
    do_reset();
    for (int k = 0; k < 64; k++) rom[k] = 17'sd65535;
    stim.delete();
    repeat (127) stim.push_back(32'sh8000_0000);
    run_stream(base);
    n_cmp++; if (outs.size() != 127) begin n_err++; $display("FAIL ext_count got=%0d want=127", outs.size()); end
    for (int i = 0; i < outs.size(); i++) begin
      n_cmp++;
      if (outs[i] !== ref_y(base + i)) begin n_err++; $display("FAIL ext_y[%0d] got=%0d want=%0d", i, $signed(outs[i]), $signed(ref_y(base + i))); end
    end
    if (outs.size() == 127) begin
      n_cmp++;
      if ($signed(outs[126]) != -1065336960) begin n_err++; $display("FAIL ext_full got=%0d want=-1065336960", $signed(outs[126])); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    for (int k = 0; k < 64; k++) rom[k] = 17'(k + 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'sd1 <<< 24;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_started got=%b want=1", busy); end
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    xs.delete();
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst_no_output got=%0d want=0", seen); end
    test_impulse(1'b0);
  endtask

  task automatic test_round();
    int base;
    int want;
`ifdef FIR_ROUND_EN
    want = 2;
`else
    want = 1;
`endif
    do_reset();
    for (int k = 0; k < 64; k++) rom[k] = (k == 0) ? 17'sd1 : 17'sd0;
    stim.delete();
    stim.push_back(32'sd3 <<< 23);
    run_stream(base);
    n_cmp++;
    if (outs.size() != 1) begin n_err++; $display("FAIL round_count got=%0d want=1", outs.size()); end
    else if ($signed(outs[0]) != want) begin n_err++; $display("FAIL round_y0 got=%0d want=%0d", $signed(outs[0]), want); end
  endtask

  task automatic test_random();
    int base;
    do_reset();
    for (int k = 0; k < 64; k++) rom[k] = 17'($urandom);
    stim.delete();
    repeat (20) stim.push_back(32'($urandom));
    run_stream(base);
    n_cmp++; if (outs.size() != 20) begin n_err++; $display("FAIL rand_count got=%0d want=20", outs.size()); end
    for (int i = 0; i < outs.size(); i++) begin
      n_cmp++;
      if (outs[i] !== ref_y(base + i)) begin n_err++; $display("FAIL rand_y[%0d] got=%0d want=%0d", i, $signed(outs[i]), $signed(ref_y(base + i))); end
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) rom[k] = '0;
    test_reset();
    test_impulse(1'b1);
    test_dc();
    test_throughput();
    test_extremes();
    test_reset_mid();
    test_round();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
